// File: rtl/secventiator_program_n.sv
// Multi-channel program controller for BCD counter automata.
// Fetches {opc, ch, target} instruction words from program ROM (odd addresses),
// strobes the selected channel, and on pause/stop stores that channel's result
// to data RAM (even addresses). All bus transfers wait for a single-cycle ack.
// Optional build macro SECV_ACK_TIMEOUT_EN: abort a transfer that sees no ack
// for 255 cycles, raising err and halting.
module secventiator_program_n #(
    parameter int AW    = 22,
    parameter int OPC_W = 2,
    parameter int NCH   = 4,
    parameter int CH_W  = 2,
    parameter int RES_W = 16,
    parameter int DW    = OPC_W + CH_W + AW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   go,
    output logic [AW-1:0]          mem_addr,
    output logic                   mem_rd,
    output logic                   mem_wr,
    input  logic [DW-1:0]          mem_rdata,
    output logic [RES_W-1:0]       mem_wdata,
    input  logic                   mem_ack,
    output logic [OPC_W-1:0]       auto_in,
    output logic [NCH-1:0]         auto_clk,
    input  logic [NCH*RES_W-1:0]   auto_out,
    output logic [AW-2:0]          pc,
    output logic                   halted,
    output logic                   err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_CAPT,
        S_WRITE,
        S_HALT
    } state_t;

    localparam logic [OPC_W-1:0] OPC_START = OPC_W'(1);
    localparam logic [OPC_W-1:0] OPC_PAUSE = OPC_W'(2);
    localparam logic [OPC_W-1:0] OPC_STOP  = OPC_W'(3);
    localparam logic [AW-2:0]    PC_ONE    = 1;

    state_t              state_q;
    state_t              state_d;
    logic [AW-2:0]       pc_q;
    logic [DW-1:0]       ir_q;
    logic [RES_W-1:0]    res_q;
    logic [OPC_W-1:0]    auto_in_q;
    logic                err_q;

    logic [OPC_W-1:0]    ir_opc;
    logic [CH_W-1:0]     ir_ch;
    logic [AW-1:0]       ir_tgt;
    logic                opc_exec;
    logic                ch_bad;
    logic [RES_W-1:0]    ch_result;
    logic                timeout;

    assign ir_opc   = ir_q[DW-1 -: OPC_W];
    assign ir_ch    = ir_q[AW +: CH_W];
    assign ir_tgt   = ir_q[AW-1:0];
    assign opc_exec = (ir_opc == OPC_START) || (ir_opc == OPC_PAUSE) || (ir_opc == OPC_STOP);
    assign ch_bad   = int'(ir_ch) >= NCH;

    assign pc        = pc_q;
    assign err       = err_q;
    assign mem_wdata = res_q;

`ifdef SECV_ACK_TIMEOUT_EN
    logic [7:0] wait_q;

    // The 255th consecutive unacknowledged bus cycle aborts the transfer.
    assign timeout = ((state_q == S_FETCH) || (state_q == S_WRITE)) && !mem_ack && (wait_q == 8'd254);

    // Wait counter: counts bus cycles without ack, restarts on every state entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= 8'd0;
        end else if (state_d != state_q) begin
            wait_q <= 8'd0;
        end else if ((state_q == S_FETCH) || (state_q == S_WRITE)) begin
            wait_q <= wait_q + 8'd1;
        end else begin
            wait_q <= 8'd0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Select the result slice of the channel named in the current instruction.
    always_comb begin
        ch_result = '0;
        for (int k = 0; k < NCH; k++) begin
            if (int'(ir_ch) == k) begin
                ch_result = auto_out[k*RES_W +: RES_W];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and state-decoded bus/automaton outputs.
    always_comb begin
        state_d  = state_q;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        mem_addr = {pc_q, 1'b1};
        halted   = 1'b0;
        auto_in  = auto_in_q;
        auto_clk = '0;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_rd = 1'b1;
                if (mem_ack) begin
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_HALT;
                end
            end
            S_DECODE: begin
                if (!opc_exec || ch_bad) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                auto_in = ir_opc;
                for (int k = 0; k < NCH; k++) begin
                    auto_clk[k] = (int'(ir_ch) == k);
                end
                state_d = (ir_opc == OPC_START) ? S_FETCH : S_CAPT;
            end
            S_CAPT: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                mem_wr   = 1'b1;
                mem_addr = ir_tgt;
                if (mem_ack) begin
                    state_d = (ir_opc == OPC_STOP) ? S_HALT : S_FETCH;
                end else if (timeout) begin
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                halted = 1'b1;
                if (go) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Program counter and instruction register load on a completed fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
            ir_q <= '0;
        end else if ((state_q == S_FETCH) && mem_ack) begin
            pc_q <= pc_q + PC_ONE;
            ir_q <= mem_rdata;
        end
    end

    // Result register captures the selected channel when leaving CAPT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0;
        end else if (state_q == S_CAPT) begin
            res_q <= ch_result;
        end
    end

    // Remember the last executed opcode so auto_in holds it between strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            auto_in_q <= '0;
        end else if (state_q == S_EXEC) begin
            auto_in_q <= ir_opc;
        end
    end

    // Sticky error: bad channel number or an aborted bus transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (((state_q == S_DECODE) && ch_bad) || timeout) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_secventiator_program_n.sv
// Directed bench for secventiator_program_n (AW=6, NCH=3 so channel 3 is invalid).
// A negedge responder models ROM/RAM with per-address ack delays and scoreboards
// channel strobes and RAM writes against queued expectations.
// Optional build macro SECV_ACK_TIMEOUT_EN adds the ack-timeout scenario.
`timescale 1ns/1ps
module tb_secventiator_program_n;

    localparam int AW    = 6;
    localparam int OPC_W = 2;
    localparam int NCH   = 3;
    localparam int CH_W  = 2;
    localparam int RES_W = 16;
    localparam int DW    = OPC_W + CH_W + AW;

    logic                   clk;
    logic                   rst;
    logic                   go;
    logic [AW-1:0]          mem_addr;
    logic                   mem_rd;
    logic                   mem_wr;
    logic [DW-1:0]          mem_rdata;
    logic [RES_W-1:0]       mem_wdata;
    logic                   mem_ack;
    logic [OPC_W-1:0]       auto_in;
    logic [NCH-1:0]         auto_clk;
    logic [NCH*RES_W-1:0]   auto_out;
    logic [AW-2:0]          pc;
    logic                   halted;
    logic                   err;

    typedef struct packed {
        logic [NCH-1:0]   strobe;
        logic [OPC_W-1:0] opc;
    } exec_t;

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [RES_W-1:0] data;
    } write_t;

    exec_t         exp_exec[$];
    write_t        exp_write[$];
    logic [DW-1:0] rom [0:31];
    int            delay_of_addr [0:63];
    logic          rd_hold;
    logic          wr_hold;
    int            n_checks;
    int            n_pass;

    secventiator_program_n #(
        .AW(AW), .OPC_W(OPC_W), .NCH(NCH), .CH_W(CH_W), .RES_W(RES_W)
    ) dut (
        .clk(clk), .rst(rst), .go(go),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .auto_in(auto_in), .auto_clk(auto_clk), .auto_out(auto_out),
        .pc(pc), .halted(halted), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] word(input logic [1:0] opc, input logic [1:0] ch, input logic [AW-1:0] tgt);
        return {opc, ch, tgt};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One-cycle go pulse; returns on the negedge after go was sampled.
    task automatic applyStimulus();
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    // Bus responder and scoreboard: checks strobes and writes, acks after a delay.
    initial begin
        int     cnt;
        logic   hold;
        exec_t  e;
        write_t w;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        cnt       = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mem_ack = 1'b0;
                cnt     = 0;
            end else begin
                if (auto_clk != '0) begin
                    e = '0;
                    if (exp_exec.size() > 0) e = exp_exec.pop_front();
                    checkOutput("exec_strobe", 32'(auto_clk), 32'(e.strobe));
                    checkOutput("exec_opcode", 32'(auto_in), 32'(e.opc));
                end
                if (mem_ack) begin
                    mem_ack = 1'b0;
                    cnt     = 0;
                end
                if (mem_rd || mem_wr) begin
                    hold = (mem_rd && rd_hold) || (mem_wr && wr_hold);
                    if (!hold && cnt >= delay_of_addr[mem_addr]) begin
                        checkOutput("rd_wr_exclusive", 32'(mem_rd & mem_wr), 32'd0);
                        if (mem_rd) begin
                            mem_rdata = rom[mem_addr[AW-1:1]];
                        end else begin
                            w = '0;
                            if (exp_write.size() > 0) w = exp_write.pop_front();
                            checkOutput("write_addr", 32'(mem_addr), 32'(w.addr));
                            checkOutput("write_data", 32'(mem_wdata), 32'(w.data));
                        end
                        mem_ack = 1'b1;
                    end else begin
                        cnt++;
                    end
                end else begin
                    cnt = 0;
                end
            end
        end
    end

    // Directed sequence.
    initial begin
        int t;
        rst      = 1'b1;
        go       = 1'b0;
        rd_hold  = 1'b0;
        wr_hold  = 1'b0;
        n_checks = 0;
        n_pass   = 0;
        auto_out = {16'h5678, 16'h0042, 16'h1234};
        for (int i = 0; i < 32; i++) rom[i] = '0;
        for (int i = 0; i < 64; i++) delay_of_addr[i] = 0;
        rom[0] = word(2'd1, 2'd2, 6'd0);
        rom[1] = word(2'd2, 2'd1, 6'd6);
        rom[2] = word(2'd3, 2'd0, 6'd2);
        rom[3] = word(2'd1, 2'd3, 6'd0);
        rom[4] = word(2'd3, 2'd2, 6'd4);
        delay_of_addr[3] = 3;
        delay_of_addr[6] = 3;

        repeat (3) @(negedge clk);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd1);
        checkOutput("rst_mem_rd", 32'(mem_rd), 32'd0);
        checkOutput("rst_mem_wr", 32'(mem_wr), 32'd0);
        checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        checkOutput("rst_auto_in", 32'(auto_in), 32'd0);
        checkOutput("rst_auto_clk", 32'(auto_clk), 32'd0);
        checkOutput("rst_pc", 32'(pc), 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("idle_no_fetch", 32'(mem_rd), 32'd0);

        exp_exec.push_back('{strobe: 3'b100, opc: 2'd1});
        exp_exec.push_back('{strobe: 3'b010, opc: 2'd2});
        exp_write.push_back('{addr: 6'd6, data: 16'h0042});
        exp_exec.push_back('{strobe: 3'b001, opc: 2'd3});
        exp_write.push_back('{addr: 6'd2, data: 16'h1234});
        exp_exec.push_back('{strobe: 3'b100, opc: 2'd3});
        exp_write.push_back('{addr: 6'd4, data: 16'h5678});

        $display("[TB] start ch2, then pause ch1 with 3 wait states");
        applyStimulus();
        checkOutput("first_fetch_addr", 32'(mem_addr), 32'd1);
        for (int i = 0; i < 50 && auto_clk == '0; i++) @(negedge clk);
        checkOutput("first_exec_seen", 32'(auto_clk != '0), 32'd1);
        checkOutput("first_exec_pc", 32'(pc), 32'd1);
        checkOutput("first_exec_no_wr", 32'(mem_wr), 32'd0);
        for (int i = 0; i < 50 && !mem_rd; i++) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checkOutput("rd_held_while_waiting", 32'(mem_rd), 32'd1);
            @(negedge clk);
        end
        checkOutput("rd_dropped_after_ack", 32'(mem_rd), 32'd0);
        checkOutput("pc_after_second_fetch", 32'(pc), 32'd2);

        $display("[TB] stop ch0, halt and hold");
        for (int i = 0; i < 100 && !halted; i++) @(negedge clk);
        checkOutput("halt_after_stop", 32'(halted), 32'd1);
        checkOutput("halt_pc", 32'(pc), 32'd3);
        checkOutput("no_err_yet", 32'(err), 32'd0);
        repeat (20) @(negedge clk);
        checkOutput("halt_pc_frozen", 32'(pc), 32'd3);
        checkOutput("halt_no_fetch", 32'(mem_rd), 32'd0);
        checkOutput("halt_still", 32'(halted), 32'd1);

        $display("[TB] resume into bad channel then stop ch2");
        applyStimulus();
        checkOutput("resume_rd", 32'(mem_rd), 32'd1);
        checkOutput("resume_addr", 32'(mem_addr), 32'd7);
        for (int i = 0; i < 100 && !halted; i++) @(negedge clk);
        checkOutput("halt_after_bad_ch", 32'(halted), 32'd1);
        checkOutput("bad_ch_err", 32'(err), 32'd1);
        checkOutput("bad_ch_pc", 32'(pc), 32'd5);

        $display("[TB] nop run through pc wrap");
        for (int i = 5; i < 32; i++) rom[i] = '0;
        rom[0] = word(2'd3, 2'd1, 6'd8);
        exp_exec.push_back('{strobe: 3'b010, opc: 2'd3});
        exp_write.push_back('{addr: 6'd8, data: 16'h0042});
        applyStimulus();
        for (int i = 0; i < 200 && !(mem_rd && pc == '0); i++) @(negedge clk);
        checkOutput("wrap_fetch_seen", 32'(mem_rd && pc == '0), 32'd1);
        checkOutput("wrap_fetch_addr", 32'(mem_addr), 32'd1);
        for (int i = 0; i < 100 && !halted; i++) @(negedge clk);
        checkOutput("wrap_halt_pc", 32'(pc), 32'd1);
        checkOutput("err_sticky", 32'(err), 32'd1);

        $display("[TB] reset during a stalled write");
        rom[1] = word(2'd2, 2'd0, 6'd10);
        exp_exec.push_back('{strobe: 3'b001, opc: 2'd2});
        wr_hold = 1'b1;
        applyStimulus();
        for (int i = 0; i < 50 && !mem_wr; i++) @(negedge clk);
        checkOutput("stalled_wr", 32'(mem_wr), 32'd1);
        checkOutput("stalled_wr_addr", 32'(mem_addr), 32'd10);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_wr", 32'(mem_wr), 32'd0);
        checkOutput("async_rst_rd", 32'(mem_rd), 32'd0);
        checkOutput("async_rst_pc", 32'(pc), 32'd0);
        checkOutput("async_rst_err", 32'(err), 32'd0);
        checkOutput("async_rst_addr", 32'(mem_addr), 32'd1);
        @(negedge clk);
        rst     = 1'b0;
        wr_hold = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("post_rst_idle", 32'(mem_rd | mem_wr | halted), 32'd0);

`ifdef SECV_ACK_TIMEOUT_EN
        $display("[TB] fetch with no ack");
        rd_hold = 1'b1;
        applyStimulus();
        t = 0;
        while (!halted && t < 400) begin
            @(negedge clk);
            t++;
        end
        checkOutput("timeout_halted", 32'(halted), 32'd1);
        checkOutput("timeout_err", 32'(err), 32'd1);
        checkOutput("timeout_rd_dropped", 32'(mem_rd), 32'd0);
        checkOutput("timeout_pc", 32'(pc), 32'd0);
        checkOutput("timeout_latency", 32'(t >= 250 && t <= 260), 32'd1);
        rd_hold = 1'b0;
`else
        t = 0;
`endif

        checkOutput("exec_queue_drained", 32'(exp_exec.size()), 32'(t * 0));
        checkOutput("write_queue_drained", 32'(exp_write.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
